sine_rom_arbiter: RTL and testbench

- Round-robin arbiter that shares the dual-port 1024 x 18 sine ROM (Sine1k2, 2-cycle read latency) among NREQ phase requesters, such as NCOs, mixers and test-tone generators.
- Up to two requests are granted per clock, one on ROM port A and one on port B.
- Addresses are registered into the ROM. A tag pipeline tracks each access so returned samples leave with a valid strobe and the requester id.
- Sits between the requesters and the ROM instance. The ROM data outputs return through this block.

---
 rtl/sine_rom_arbiter.sv | 147 ++++++++++++++
 tb/tb_sine_rom_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sine_rom_arbiter.sv
// Round-robin arbiter sharing a dual-port sine ROM among NREQ phase requesters.
// Two grants per clock (ports A/B); a tag pipeline returns samples with requester id.
module sine_rom_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 10,
    parameter int DW   = 18,
    parameter int LAT  = 2,
    parameter int IW   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   addr,
    output logic [NREQ-1:0]      gnt,
    output logic [AW-1:0]        rom_aa,
    output logic [AW-1:0]        rom_ab,
    input  logic [DW-1:0]        rom_da,
    input  logic [DW-1:0]        rom_db,
    output logic                 rsp_va,
    output logic [IW-1:0]        rsp_ida,
    output logic [DW-1:0]        rsp_da,
    output logic                 rsp_vb,
    output logic [IW-1:0]        rsp_idb,
    output logic [DW-1:0]        rsp_db
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic          win_a_v, win_b_v;
    logic [IW-1:0] win_a, win_b;
    int            dist_a, best_a, dist_b, best_b;

    logic [AW-1:0] rom_aa_q, rom_aa_d, rom_ab_q, rom_ab_d;
    logic          va_q  [0:LAT];
    logic          va_d  [0:LAT];
    logic          vb_q  [0:LAT];
    logic          vb_d  [0:LAT];
    logic [IW-1:0] ida_q [0:LAT];
    logic [IW-1:0] ida_d [0:LAT];
    logic [IW-1:0] idb_q [0:LAT];
    logic [IW-1:0] idb_d [0:LAT];

    // Port A: nearest request at or after ptr; port B: nearest after the A winner.
    always_comb begin
        win_a_v = 1'b0;
        win_a   = '0;
        best_a  = NREQ;
        dist_a  = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i]) begin
                dist_a = (i >= int'(ptr_q)) ? i - int'(ptr_q) : i + NREQ - int'(ptr_q);
                if (dist_a < best_a) begin
                    best_a  = dist_a;
                    win_a_v = 1'b1;
                    win_a   = IW'(i);
                end
            end
        end
        win_b_v = 1'b0;
        win_b   = '0;
        best_b  = NREQ;
        dist_b  = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_a_v && req[i] && (i != int'(win_a))) begin
                dist_b = (i > int'(win_a)) ? i - int'(win_a) : i + NREQ - int'(win_a);
                if (dist_b < best_b) begin
                    best_b  = dist_b;
                    win_b_v = 1'b1;
                    win_b   = IW'(i);
                end
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = !rst && ((win_a_v && (win_a == IW'(i))) ||
                              (win_b_v && (win_b == IW'(i))));
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (win_b_v) begin
            ptr_d = (win_b == IW'(NREQ - 1)) ? '0 : win_b + IW'(1);
        end else if (win_a_v) begin
            ptr_d = (win_a == IW'(NREQ - 1)) ? '0 : win_a + IW'(1);
        end
    end

    // Idle ports keep their last address so the ROM address bus stays quiet.
    always_comb begin
        rom_aa_d = rom_aa_q;
        rom_ab_d = rom_ab_q;
        for (int i = 0; i < NREQ; i++) begin
            if (win_a_v && (win_a == IW'(i))) rom_aa_d = addr[i*AW +: AW];
            if (win_b_v && (win_b == IW'(i))) rom_ab_d = addr[i*AW +: AW];
        end
    end

    always_comb begin
        va_d[0]  = win_a_v;
        ida_d[0] = win_a_v ? win_a : '0;
        vb_d[0]  = win_b_v;
        idb_d[0] = win_b_v ? win_b : '0;
        for (int k = 1; k <= LAT; k++) begin
            va_d[k]  = va_q[k-1];
            ida_d[k] = ida_q[k-1];
            vb_d[k]  = vb_q[k-1];
            idb_d[k] = idb_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q    <= '0;
            rom_aa_q <= '0;
            rom_ab_q <= '0;
            for (int k = 0; k <= LAT; k++) begin
                va_q[k]  <= 1'b0;
                ida_q[k] <= '0;
                vb_q[k]  <= 1'b0;
                idb_q[k] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            rom_aa_q <= rom_aa_d;
            rom_ab_q <= rom_ab_d;
            for (int k = 0; k <= LAT; k++) begin
                va_q[k]  <= va_d[k];
                ida_q[k] <= ida_d[k];
                vb_q[k]  <= vb_d[k];
                idb_q[k] <= idb_d[k];
            end
        end
    end

    assign rom_aa  = rom_aa_q;
    assign rom_ab  = rom_ab_q;
    assign rsp_va  = va_q[LAT];
    assign rsp_ida = ida_q[LAT];
    assign rsp_vb  = vb_q[LAT];
    assign rsp_idb = idb_q[LAT];
    assign rsp_da  = rom_da;
    assign rsp_db  = rom_db;

endmodule

// File: tb/tb_sine_rom_arbiter.sv
// Bench for sine_rom_arbiter: behavioural ROM, queue-based round-robin model and
// per-cycle response scoreboard; directed scenarios followed by random traffic.
module tb_sine_rom_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 10;
    localparam int DW   = 18;
    localparam int LAT  = 2;
    localparam int IW   = 3;
    localparam int MAXC = 2048;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*AW-1:0]  addr;
    logic [NREQ-1:0]     gnt;
    logic [AW-1:0]       rom_aa, rom_ab;
    logic [DW-1:0]       rom_da, rom_db;
    logic                rsp_va, rsp_vb;
    logic [IW-1:0]       rsp_ida, rsp_idb;
    logic [DW-1:0]       rsp_da, rsp_db;

    always #5 clk = ~clk;

    sine_rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .LAT(LAT), .IW(IW)) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .gnt(gnt),
        .rom_aa(rom_aa), .rom_ab(rom_ab), .rom_da(rom_da), .rom_db(rom_db),
        .rsp_va(rsp_va), .rsp_ida(rsp_ida), .rsp_da(rsp_da),
        .rsp_vb(rsp_vb), .rsp_idb(rsp_idb), .rsp_db(rsp_db)
    );

    // Sine ROM: 2-cycle latency from registered address to data.
    logic [DW-1:0] sine_tbl [0:1023];
    logic [DW-1:0] ra1, ra2, rb1, rb2;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ra1 <= '0; ra2 <= '0; rb1 <= '0; rb2 <= '0;
        end else begin
            ra1 <= sine_tbl[rom_aa]; ra2 <= ra1;
            rb1 <= sine_tbl[rom_ab]; rb2 <= rb1;
        end
    end
    assign rom_da = ra2;
    assign rom_db = rb2;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc;
    int            m_ptr;
    logic [AW-1:0] m_aa, m_ab;
    bit            exp_va  [MAXC];
    bit            exp_vb  [MAXC];
    int            exp_ida [MAXC];
    int            exp_idb [MAXC];
    logic [DW-1:0] exp_da  [MAXC];
    logic [DW-1:0] exp_db  [MAXC];
    logic [NREQ-1:0] last_gnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [NREQ*AW-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
        logic [NREQ*AW-1:0] v;
        v = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
        return v;
    endfunction

    // One clock: apply inputs, check this cycle against the model, advance the model.
    task automatic step(input logic [NREQ-1:0] r, input logic [NREQ*AW-1:0] a);
        int order[$];
        int wa, wb, id;
        logic [NREQ-1:0] eg;
        req  = r;
        addr = a;
        @(negedge clk);
        order = {};
        for (int k = 0; k < NREQ; k++) begin
            id = (m_ptr + k) % NREQ;
            if (r[id]) order.push_back(id);
        end
        wa = (order.size() > 0) ? order[0] : -1;
        wb = (order.size() > 1) ? order[1] : -1;
        eg = '0;
        if (wa >= 0) eg[wa] = 1'b1;
        if (wb >= 0) eg[wb] = 1'b1;
        check_eq("gnt", 32'(gnt), 32'(eg));
        check_eq("rsp_va", 32'(rsp_va), 32'(exp_va[cyc]));
        if (exp_va[cyc]) begin
            check_eq("rsp_ida", 32'(rsp_ida), exp_ida[cyc]);
            check_eq("rsp_da", 32'(rsp_da), 32'(exp_da[cyc]));
        end
        check_eq("rsp_vb", 32'(rsp_vb), 32'(exp_vb[cyc]));
        if (exp_vb[cyc]) begin
            check_eq("rsp_idb", 32'(rsp_idb), exp_idb[cyc]);
            check_eq("rsp_db", 32'(rsp_db), 32'(exp_db[cyc]));
        end
        check_eq("rom_aa", 32'(rom_aa), 32'(m_aa));
        check_eq("rom_ab", 32'(rom_ab), 32'(m_ab));
        if (wa >= 0) begin
            m_aa = a[wa*AW +: AW];
            exp_va[cyc+1+LAT]  = 1'b1;
            exp_ida[cyc+1+LAT] = wa;
            exp_da[cyc+1+LAT]  = sine_tbl[m_aa];
        end
        if (wb >= 0) begin
            m_ab = a[wb*AW +: AW];
            exp_vb[cyc+1+LAT]  = 1'b1;
            exp_idb[cyc+1+LAT] = wb;
            exp_db[cyc+1+LAT]  = sine_tbl[m_ab];
        end
        if (wb >= 0)      m_ptr = (wb + 1) % NREQ;
        else if (wa >= 0) m_ptr = (wa + 1) % NREQ;
        last_gnt = eg;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0);
    endtask

    // Asynchronous reset pulse: outputs must clear at once, in-flight accesses vanish.
    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_rsp_va", 32'(rsp_va), 0);
        check_eq("rst_rsp_vb", 32'(rsp_vb), 0);
        check_eq("rst_rsp_ida", 32'(rsp_ida), 0);
        check_eq("rst_rsp_idb", 32'(rsp_idb), 0);
        check_eq("rst_rom_aa", 32'(rom_aa), 0);
        check_eq("rst_rom_ab", 32'(rom_ab), 0);
        for (int c = cyc; c < MAXC; c++) begin
            exp_va[c] = 1'b0;
            exp_vb[c] = 1'b0;
        end
        m_ptr = 0;
        m_aa  = '0;
        m_ab  = '0;
        @(negedge clk);
        check_eq("rst_gnt", 32'(gnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
    endtask

    logic [NREQ-1:0]    r_cur;
    logic [NREQ*AW-1:0] a_cur;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            real v;
            v = 131071.0 * $sin(2.0 * 3.14159265358979 * i / 1024.0);
            sine_tbl[i] = DW'(int'(v));
        end
        rst   = 1'b1;
        req   = '1;
        addr  = '0;
        cyc   = 0;
        m_ptr = 0;
        m_aa  = '0;
        m_ab  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_gnt", 32'(gnt), 0);
        check_eq("reset_rsp_va", 32'(rsp_va), 0);
        check_eq("reset_rsp_vb", 32'(rsp_vb), 0);
        check_eq("reset_rsp_ida", 32'(rsp_ida), 0);
        check_eq("reset_rsp_idb", 32'(rsp_idb), 0);
        check_eq("reset_rom_aa", 32'(rom_aa), 0);
        check_eq("reset_rom_ab", 32'(rom_ab), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = '0;

        step(4'b0001, pack4(0, 0, 0, 0));
        idle(4);
        step(4'b0110, pack4(0, 256, 768, 0));
        idle(4);
        for (int i = 0; i < 8; i++) step(4'b1111, pack4(0, 256, 512, 768));
        idle(4);
        for (int k = 0; k < 10; k++) step(4'b1000, pack4(0, 0, 0, k));
        idle(4);
        step(4'b1111, pack4(10, 20, 30, 40));
        step(4'b1111, pack4(50, 60, 70, 80));
        pulse_reset();
        idle(5);
        step(4'b1111, pack4(1, 2, 3, 4));
        idle(4);
        step(4'b0101, pack4(128, 0, 128, 0));
        idle(4);

        r_cur = '0;
        a_cur = '0;
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                pulse_reset();
                r_cur = '0;
            end
            step(r_cur, a_cur);
            for (int i = 0; i < NREQ; i++) begin
                if (r_cur[i] && !last_gnt[i]) begin
                    if ($urandom_range(0, 9) == 0) r_cur[i] = 1'b0;
                end else begin
                    r_cur[i] = ($urandom_range(0, 2) != 0);
                    a_cur[i*AW +: AW] = AW'($urandom);
                end
            end
        end
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
